// File: rtl/pwm_decoder.sv
// PWM receiver: measures 2^N-tick framed PWM and recovers the N-bit duty value.
// Optional glitch filter on the conditioned input: define PWM_DECODER_GLITCH_FILTER_EN.
module pwm_decoder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step,
   input  logic         pwm_in,
   output logic [N-1:0] duty,
   output logic         valid,
   output logic         err,
   output logic         level
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   localparam logic [N:0]   FULL     = {1'b1, {N{1'b0}}};
   localparam logic [N+1:0] FULL_SUM = {2'b01, {N{1'b0}}};

   logic         sync_p0, sync_p1;
   logic         level_q;
   logic         rise, fall;

   state_t       state_q, state_d;
   logic [N:0]   hi_q, hi_d, lo_q, lo_d;
   logic         partial_q, partial_d;
   logic [N-1:0] duty_d;
   logic         valid_d, err_d;

   logic [N:0]   tick, hi_inc, lo_inc;
   logic [N+1:0] sum;

   // Input conditioning: two-flop synchronizer, optional hold-for-two filter, edge history
`ifdef PWM_DECODER_GLITCH_FILTER_EN
   logic sync_p2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
      end else begin
         sync_p0 <= pwm_in;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
         if (sync_p1 == sync_p2)
            level <= sync_p2;
         level_q <= level;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         level_q <= 1'b0;
      end else begin
         sync_p0 <= pwm_in;
         sync_p1 <= sync_p0;
         level_q <= sync_p1;
      end
   end

   assign level = sync_p1;
`endif

   assign rise = level & ~level_q;
   assign fall = ~level & level_q;

   // Phase counters: a step coinciding with an edge is credited to the new phase
   assign tick   = {{N{1'b0}}, step};
   assign hi_inc = hi_q + tick;
   assign lo_inc = lo_q + tick;
   assign sum    = {1'b0, hi_q} + {1'b0, lo_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         partial_q <= 1'b1;
         duty      <= '0;
         valid     <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         partial_q <= partial_d;
         duty      <= duty_d;
         valid     <= valid_d;
         err       <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      partial_d = partial_q;
      duty_d    = duty;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = HIGH;
               hi_d    = tick;
            end else if (lo_inc == FULL) begin
               duty_d  = {N{level}};
               valid_d = 1'b1;
               lo_d    = '0;
            end else begin
               lo_d = lo_inc;
            end
         end

         HIGH: begin
            if (fall) begin
               state_d = LOW;
               lo_d    = tick;
            end else if (hi_inc == FULL) begin
               // Stuck high: report full duty once per period
               duty_d    = '1;
               valid_d   = 1'b1;
               partial_d = 1'b1;
               hi_d      = '0;
            end else begin
               hi_d = hi_inc;
            end
         end

         LOW: begin
            if (rise) begin
               state_d   = HIGH;
               hi_d      = tick;
               partial_d = 1'b0;
               if (!partial_q) begin
                  if (sum == FULL_SUM) begin
                     duty_d  = hi_q[N-1:0];
                     valid_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end else if (lo_inc == FULL) begin
               duty_d    = '0;
               valid_d   = 1'b1;
               partial_d = 1'b1;
               state_d   = IDLE;
               lo_d      = '0;
            end else begin
               lo_d = lo_inc;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: framed PWM patterns with hand-computed duty/err results.
module tb_pwm_decoder;

   localparam int N = 8;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
   localparam int D_MIN = 2;
`else
   localparam int D_MIN = 1;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         step;
   logic         pwm_in;
   logic [N-1:0] duty;
   logic         valid;
   logic         err;
   logic         level;

   int n_cmp = 0;
   int n_bad = 0;

   int           cyc = 0;
   int           vcnt = 0, ecnt = 0, vgap = 0, vtime = 0, both = 0, vrun = 0;
   logic [N-1:0] vlast = '0;
   logic         valid_prev = 1'b0;

   int step_div = 1;
   int step_ph  = 0;
   int v0, e0;
   int sweep [3];

   pwm_decoder #(.N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .step   (step),
      .pwm_in (pwm_in),
      .duty   (duty),
      .valid  (valid),
      .err    (err),
      .level  (level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record valid/err pulses between clock edges
   always @(negedge clk) begin
      if (valid) begin
         vcnt  <= vcnt + 1;
         vlast <= duty;
         vgap  <= cyc - vtime;
         vtime <= cyc;
      end
      if (err)
         ecnt <= ecnt + 1;
      if (valid && err)
         both <= both + 1;
      if (valid && valid_prev)
         vrun <= vrun + 1;
      valid_prev <= valid;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      step_ph = (step_ph + 1) % step_div;
      step    = (step_ph == 0);
   endtask

   task automatic hold(input logic lv, input int n);
      pwm_in = lv;
      repeat (n) tick();
   endtask

   task automatic frames(input int hi, input int lo, input int k);
      repeat (k) begin
         hold(1'b1, hi);
         hold(1'b0, lo);
      end
   endtask

   initial begin
      rst    = 1'b1;
      pwm_in = 1'b0;
      step   = 1'b1;
      repeat (3) tick();
      check_eq("reset_duty",  duty,  0);
      check_eq("reset_valid", valid, 0);
      check_eq("reset_err",   err,   0);
      check_eq("reset_level", level, 0);
      rst = 1'b0;
      repeat (5) tick();

      // 64/192 framing: first frame discarded, then one valid per period
      v0 = vcnt; e0 = ecnt;
      frames(64, 192, 4);
      check_eq("lock64_count", vcnt - v0, 2);
      check_eq("lock64_duty",  vlast, 64);
      check_eq("lock64_err",   ecnt - e0, 0);
      check_eq("lock64_gap",   vgap, 256);

      sweep[0] = D_MIN; sweep[1] = 127; sweep[2] = 254;
      for (int i = 0; i < 3; i++) begin
         frames(sweep[i], 256 - sweep[i], 3);
         check_eq("sweep_duty", vlast, sweep[i]);
         check_eq("sweep_gap",  vgap, 256);
      end

      // Period 200: every complete frame flags err, duty keeps 254
      v0 = vcnt; e0 = ecnt;
      frames(50, 150, 4);
      check_eq("p200_valid", vcnt - v0, 1);
      check_eq("p200_err",   ecnt - e0, 3);
      check_eq("p200_duty",  duty, 254);

      // Stuck high: last short frame errs, then full duty every 256 ticks
      v0 = vcnt; e0 = ecnt;
      hold(1'b1, 600);
      check_eq("high_count", vcnt - v0, 2);
      check_eq("high_err",   ecnt - e0, 1);
      check_eq("high_duty",  vlast, 255);
      check_eq("high_gap",   vgap, 256);

      // Relock, then stuck low: zero duty 256 ticks after the falling edge
      v0 = vcnt;
      hold(1'b0, 100);
      frames(64, 192, 3);
      hold(1'b0, 200);
      check_eq("low_count", vcnt - v0, 3);
      check_eq("low_duty",  vlast, 0);
      check_eq("low_gap",   vgap, 319);

      // Reset in the middle of a high phase
      frames(64, 192, 3);
      check_eq("prerst_duty", duty, 64);
      hold(1'b1, 30);
      rst = 1'b1;
      #1;
      check_eq("midrst_duty",  duty,  0);
      check_eq("midrst_valid", valid, 0);
      check_eq("midrst_err",   err,   0);
      check_eq("midrst_level", level, 0);
      tick();
      tick();
      rst = 1'b0;
      hold(1'b1, 32);
      hold(1'b0, 192);
      v0 = vcnt;
      frames(64, 192, 1);
      check_eq("postrst_discard", vcnt - v0, 0);
      check_eq("postrst_duty0",   duty, 0);
      frames(64, 192, 2);
      check_eq("postrst_count", vcnt - v0, 2);
      check_eq("postrst_duty",  vlast, 64);

      // step every 4th clk: 10 high / 246 low ticks
      step_div = 4;
      step_ph  = 0;
      frames(40, 984, 3);
      check_eq("step4_duty", vlast, 10);
      check_eq("step4_gap",  vgap, 1024);
      step_div = 1;
      step_ph  = 0;

      // One-clk low glitch inside a 64-clk high phase
      frames(64, 192, 3);
      v0 = vcnt; e0 = ecnt;
      hold(1'b1, 30);
      hold(1'b0, 1);
      hold(1'b1, 33);
      hold(1'b0, 192);
      frames(64, 192, 1);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
      check_eq("glitch_valid", vcnt - v0, 2);
      check_eq("glitch_err",   ecnt - e0, 0);
`else
      check_eq("glitch_valid", vcnt - v0, 1);
      check_eq("glitch_err",   ecnt - e0, 2);
`endif
      check_eq("glitch_duty", vlast, 64);

      check_eq("valid_err_overlap", both, 0);
      check_eq("valid_pulse_width", vrun, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
